// File: rtl/score_lives_keeper_pkg.sv
// Shared types and helpers for the Pac-Man game bookkeeping logic.
// The object codes and phase encoding match what the sprite controllers
// and the display logic expect.
package score_lives_keeper_pkg;

   // Object codes reported by pacman_loc_ctrl after each move
   typedef enum logic [3:0] {
      COLL_NONE  = 4'd0,
      COLL_WALL  = 4'd1,
      COLL_PILL  = 4'd2,
      COLL_POWER = 4'd3,
      COLL_GHOST = 4'd4
   } coll_e;

   // Game phase as seen on the phase output
   typedef enum logic [1:0] {
      PHASE_PLAY     = 2'd0,
      PHASE_HIT_HOLD = 2'd1,
      PHASE_CLEAR    = 2'd2,
      PHASE_OVER     = 2'd3
   } phase_e;

   // Plain constants for the FSM state register (legacy-compatible form)
   localparam logic [1:0] ST_PLAY     = 2'd0;
   localparam logic [1:0] ST_HIT_HOLD = 2'd1;
   localparam logic [1:0] ST_CLEAR    = 2'd2;
   localparam logic [1:0] ST_OVER     = 2'd3;

   // One BCD digit add: returns {carry_out, digit}. Inputs are assumed to be
   // valid BCD (0..9), so the raw sum never exceeds 19.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
      logic [4:0] raw;
      raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      if (raw > 5'd9) begin
         bcd_digit_add = {1'b1, 4'(raw - 5'd10)};
      end else begin
         bcd_digit_add = {1'b0, raw[3:0]};
      end
   endfunction

endpackage

// File: rtl/score_lives_keeper_adder.sv
// Adds a single BCD digit to a 4-digit BCD score. The carry ripples through
// all four digits combinationally; any carry out of the thousands digit
// clamps the result to 9999.
import score_lives_keeper_pkg::*;

module bcd_saturating_adder (
   input  logic [15:0] score_in,
   input  logic [3:0]  addend,
   output logic [15:0] score_out
);

   logic [4:0] d0_s;
   logic [4:0] d1_s;
   logic [4:0] d2_s;
   logic [4:0] d3_s;

   // Ripple the carry digit by digit and saturate on overflow
   always_comb begin
      d0_s = bcd_digit_add(score_in[3:0],   addend, 1'b0);
      d1_s = bcd_digit_add(score_in[7:4],   4'd0,   d0_s[4]);
      d2_s = bcd_digit_add(score_in[11:8],  4'd0,   d1_s[4]);
      d3_s = bcd_digit_add(score_in[15:12], 4'd0,   d2_s[4]);
      if (d3_s[4]) begin
         score_out = 16'h9999;
      end else begin
         score_out = {d3_s[3:0], d2_s[3:0], d1_s[3:0], d0_s[3:0]};
      end
   end

endmodule

// File: rtl/score_lives_keeper.sv
// Game bookkeeping: BCD score, pills remaining, lives and the game phase.
// Collision reports from pacman_loc_ctrl and the ghost-contact level feed a
// small phase FSM that also drives the sprite/map reset requests.
import score_lives_keeper_pkg::*;

module score_lives_keeper #(
   parameter int unsigned PILL_TOTAL  = 244,
   parameter int unsigned START_LIVES = 3,
   parameter logic [3:0]  PILL_PTS    = 4'd1,
   parameter logic [3:0]  POWER_PTS   = 4'd5,
   parameter int unsigned HOLD_CYCLES = 250000000
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        new_game,
   input  logic        move_done,
   input  logic [3:0]  collision_type,
   input  logic        ghost_hit,
   output logic [15:0] score_bcd,
   output logic [8:0]  pills_left,
   output logic [2:0]  lives,
   output logic [1:0]  phase,
   output logic        sprite_reset,
   output logic        map_reload
);

   localparam int unsigned     CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [8:0]      PILLS_INIT = 9'(PILL_TOTAL);
   localparam logic [2:0]      LIVES_INIT = 3'(START_LIVES);

   logic [15:0]      score_r;
   logic [8:0]       pills_r;
   logic [2:0]       lives_r;
   logic [1:0]       phase_r;
   logic [CNT_W-1:0] hold_cnt_r;
   logic             ghost_prev_r;
   logic             sprite_reset_r;
   logic             map_reload_r;

   logic [15:0]      score_nxt_s;
   logic [8:0]       pills_nxt_s;
   logic [2:0]       lives_nxt_s;
   logic [1:0]       phase_nxt_s;
   logic [CNT_W-1:0] hold_cnt_nxt_s;
   logic             map_reload_nxt_s;

   logic             pill_strobe_s;
   logic             ghost_edge_s;
   logic [3:0]       addend_s;
   logic [15:0]      score_sum_s;

   assign pill_strobe_s = move_done & ((collision_type == COLL_PILL) |
                                       (collision_type == COLL_POWER));
   assign addend_s      = (collision_type == COLL_POWER) ? POWER_PTS : PILL_PTS;
   // The previous ghost level is sampled every cycle regardless of phase, so
   // contact that persists across a phase change never looks like a new edge.
   assign ghost_edge_s  = ghost_hit & ~ghost_prev_r;

   bcd_saturating_adder u_adder (
      .score_in  (score_r),
      .addend    (addend_s),
      .score_out (score_sum_s)
   );

   // Next-state logic for the phase FSM and all bookkeeping counters
   always_comb begin
      score_nxt_s      = score_r;
      pills_nxt_s      = pills_r;
      lives_nxt_s      = lives_r;
      phase_nxt_s      = phase_r;
      hold_cnt_nxt_s   = hold_cnt_r;
      map_reload_nxt_s = 1'b0;

      if (new_game) begin
         score_nxt_s    = 16'h0000;
         pills_nxt_s    = PILLS_INIT;
         lives_nxt_s    = LIVES_INIT;
         phase_nxt_s    = ST_PLAY;
         hold_cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
         case (phase_r)
            ST_PLAY: begin
               // Pill credit first; ghost handling sees the updated pill count
               if (pill_strobe_s) begin
                  score_nxt_s = score_sum_s;
                  if (pills_r != 9'd0) begin
                     pills_nxt_s = pills_r - 9'd1;
                  end else begin
                     pills_nxt_s = 9'd0;
                  end
               end else begin
                  score_nxt_s = score_r;
               end

               if (pill_strobe_s && (pills_nxt_s == 9'd0)) begin
                  // Clearing the board takes priority over a ghost hit
                  phase_nxt_s      = ST_CLEAR;
                  hold_cnt_nxt_s   = HOLD_LOAD;
                  map_reload_nxt_s = 1'b1;
               end else if (ghost_edge_s) begin
                  if (lives_r != 3'd0) begin
                     lives_nxt_s = lives_r - 3'd1;
                  end else begin
                     lives_nxt_s = 3'd0;
                  end
                  if (lives_nxt_s == 3'd0) begin
                     phase_nxt_s = ST_OVER;
                  end else begin
                     phase_nxt_s    = ST_HIT_HOLD;
                     hold_cnt_nxt_s = HOLD_LOAD;
                  end
               end else begin
                  phase_nxt_s = ST_PLAY;
               end
            end
            ST_HIT_HOLD: begin
               if (hold_cnt_r == {CNT_W{1'b0}}) begin
                  phase_nxt_s = ST_PLAY;
               end else begin
                  hold_cnt_nxt_s = hold_cnt_r - 1'b1;
               end
            end
            ST_CLEAR: begin
               if (hold_cnt_r == {CNT_W{1'b0}}) begin
                  phase_nxt_s = ST_PLAY;
                  pills_nxt_s = PILLS_INIT;
               end else begin
                  hold_cnt_nxt_s = hold_cnt_r - 1'b1;
               end
            end
            ST_OVER: begin
               phase_nxt_s = ST_OVER;
            end
            default: begin
               phase_nxt_s = ST_PLAY;
            end
         endcase
      end
   end

   // State registers; outputs are taken straight from registers
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         score_r        <= 16'h0000;
         pills_r        <= PILLS_INIT;
         lives_r        <= LIVES_INIT;
         phase_r        <= ST_PLAY;
         hold_cnt_r     <= {CNT_W{1'b0}};
         ghost_prev_r   <= 1'b0;
         sprite_reset_r <= 1'b0;
         map_reload_r   <= 1'b0;
      end else begin
         score_r        <= score_nxt_s;
         pills_r        <= pills_nxt_s;
         lives_r        <= lives_nxt_s;
         phase_r        <= phase_nxt_s;
         hold_cnt_r     <= hold_cnt_nxt_s;
         ghost_prev_r   <= ghost_hit;
         sprite_reset_r <= (phase_nxt_s != ST_PLAY);
         map_reload_r   <= map_reload_nxt_s;
      end
   end

   assign score_bcd    = score_r;
   assign pills_left   = pills_r;
   assign lives        = lives_r;
   assign phase        = phase_r;
   assign sprite_reset = sprite_reset_r;
   assign map_reload   = map_reload_r;

endmodule

// File: tb/tb_score_lives_keeper.sv
// Self-checking bench for score_lives_keeper: directed scenarios plus a
// randomized run, all compared each cycle against an integer game model.
module tb_score_lives_keeper;

   localparam int HOLD  = 8;
   localparam int TOTAL = 244;
   localparam int LIVES0 = 3;

   logic        CLOCK_50;
   logic        reset_n;
   logic        new_game;
   logic        move_done;
   logic [3:0]  collision_type;
   logic        ghost_hit;
   logic [15:0] score_bcd;
   logic [8:0]  pills_left;
   logic [2:0]  lives;
   logic [1:0]  phase;
   logic        sprite_reset;
   logic        map_reload;

   int n_checks;
   int n_pass;

   // model state (plain integers, phase 0=PLAY 1=HIT_HOLD 2=CLEAR 3=OVER)
   int m_score, m_pills, m_lives, m_phase, m_hold;
   bit m_prev_ghost, m_reload;

   score_lives_keeper #(.HOLD_CYCLES(HOLD)) dut (
      .CLOCK_50       (CLOCK_50),
      .reset_n        (reset_n),
      .new_game       (new_game),
      .move_done      (move_done),
      .collision_type (collision_type),
      .ghost_hit      (ghost_hit),
      .score_bcd      (score_bcd),
      .pills_left     (pills_left),
      .lives          (lives),
      .phase          (phase),
      .sprite_reset   (sprite_reset),
      .map_reload     (map_reload)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_score = 0; m_pills = TOTAL; m_lives = LIVES0; m_phase = 0;
      m_hold = 0; m_prev_ghost = 1'b0; m_reload = 1'b0;
   endtask

   // One clock edge of game rules, written from the game description
   task automatic model_step(input bit ng, input bit md, input int ct, input bit gh);
      bit cleared;
      m_reload = 1'b0;
      if (ng) begin
         m_score = 0; m_pills = TOTAL; m_lives = LIVES0; m_phase = 0; m_hold = 0;
      end else if (m_phase == 0) begin
         cleared = 1'b0;
         if (md && (ct == 2 || ct == 3)) begin
            m_score = m_score + ((ct == 3) ? 5 : 1);
            if (m_score > 9999) m_score = 9999;
            if (m_pills > 0) m_pills = m_pills - 1;
            if (m_pills == 0) cleared = 1'b1;
         end
         if (cleared) begin
            m_phase = 2; m_hold = HOLD; m_reload = 1'b1;
         end else if (gh && !m_prev_ghost) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_phase = 3;
            else begin m_phase = 1; m_hold = HOLD; end
         end
      end else if (m_phase == 1) begin
         m_hold = m_hold - 1;
         if (m_hold == 0) m_phase = 0;
      end else if (m_phase == 2) begin
         m_hold = m_hold - 1;
         if (m_hold == 0) begin m_phase = 0; m_pills = TOTAL; end
      end
      m_prev_ghost = gh;
   endtask

   task automatic compare_all();
      chk("score", score_bcd, to_bcd(m_score));
      chk("pills", pills_left, m_pills);
      chk("lives", lives, m_lives);
      chk("phase", phase, m_phase);
      chk("sprite_reset", sprite_reset, (m_phase != 0));
      chk("map_reload", map_reload, m_reload);
   endtask

   task automatic step(input logic ng, input logic md, input logic [3:0] ct, input logic gh);
      new_game = ng; move_done = md; collision_type = ct; ghost_hit = gh;
      @(posedge CLOCK_50);
      model_step(ng, md, int'(ct), gh);
      #1;
      compare_all();
   endtask

   initial begin
      int pre_pills;
      n_checks = 0; n_pass = 0;
      reset_n = 1'b0; new_game = 1'b0; move_done = 1'b0;
      collision_type = 4'd0; ghost_hit = 1'b0;
      model_reset();
      repeat (2) @(posedge CLOCK_50);
      #1;
      compare_all();
      #3 reset_n = 1'b1;

      // 1: three normal pills
      repeat (3) step(1'b0, 1'b1, 4'd2, 1'b0);
      chk("t1_score", score_bcd, 16'h0003);
      chk("t1_pills", pills_left, 241);
      chk("t1_phase", phase, 2'd0);

      // randomized play, including invalid object codes and occasional new_game
      begin
         logic gh_r;
         gh_r = 1'b0;
         for (int i = 0; i < 1500; i++) begin
            logic [3:0] ct;
            if ($urandom_range(0, 15) == 0) gh_r = ~gh_r;
            if ($urandom_range(0, 3) == 0) ct = 4'($urandom_range(0, 15));
            else ct = 4'($urandom_range(0, 4));
            step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), ct, gh_r);
         end
      end

      // 2: drive the score to 9998 then overflow it with a power pill
      step(1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 6000 && m_score < 9998; i++) begin
         step(1'b0, 1'b1, (m_score <= 9993) ? 4'd3 : 4'd2, 1'b0);
      end
      for (int i = 0; i < 20 && m_phase != 0; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t2_pre", score_bcd, 16'h9998);
      pre_pills = m_pills;
      step(1'b0, 1'b1, 4'd3, 1'b0);
      chk("t2_sat", score_bcd, 16'h9999);
      chk("t2_pills", pills_left, pre_pills - 1);

      // 3: ghost held 10 cycles costs one life; PLAY returns after HOLD cycles
      step(1'b1, 1'b0, 4'd0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 1'b0, 4'd0, 1'b1);
         if (k == 1) begin
            chk("t3_lives", lives, 3'd2);
            chk("t3_phase", phase, 2'd1);
            chk("t3_sprite", sprite_reset, 1'b1);
         end
         if (k == 8) chk("t3_hold_end", phase, 2'd1);
         if (k == 9) chk("t3_play", phase, 2'd0);
         if (k == 10) chk("t3_once", lives, 3'd2);
      end
      step(1'b0, 1'b0, 4'd0, 1'b0);

      // 5: last pill together with a ghost edge clears the board
      step(1'b1, 1'b0, 4'd0, 1'b0);
      repeat (TOTAL - 1) step(1'b0, 1'b1, 4'd2, 1'b0);
      chk("t5_pills1", pills_left, 9'd1);
      step(1'b0, 1'b1, 4'd2, 1'b1);
      chk("t5_clear", phase, 2'd2);
      chk("t5_reload", map_reload, 1'b1);
      chk("t5_lives", lives, 3'd3);
      step(1'b0, 1'b0, 4'd0, 1'b1);
      chk("t5_pulse", map_reload, 1'b0);
      repeat (HOLD - 1) step(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t5_back", phase, 2'd0);
      chk("t5_refill", pills_left, 9'd244);

      // 6: asynchronous reset in the middle of HIT_HOLD
      step(1'b1, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b1);
      step(1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("t6_phase", phase, 2'd0);
      chk("t6_lives", lives, 3'd3);
      chk("t6_sprite", sprite_reset, 1'b0);
      compare_all();
      #2 reset_n = 1'b1;

      // 4: lose all lives, then pills are ignored in OVER
      for (int n = 0; n < 3; n++) begin
         step(1'b0, 1'b0, 4'd0, 1'b1);
         repeat (HOLD + 1) step(1'b0, 1'b0, 4'd0, 1'b0);
      end
      chk("t4_lives", lives, 3'd0);
      chk("t4_over", phase, 2'd3);
      repeat (3) step(1'b0, 1'b1, 4'd2, 1'b0);
      chk("t4_score", score_bcd, 16'h0000);
      step(1'b1, 1'b0, 4'd0, 1'b0);
      chk("t6_newgame_lives", lives, 3'd3);
      chk("t6_newgame_phase", phase, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
